// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and byte/word slicing helpers.
// Latency: none (package only).
// Backpressure: not applicable.
package aes_pkg;

   localparam int KEY_BITS = 128;
   localparam int NR       = 10;

   typedef enum logic {IDLE, EMIT} sched_state_t;

   // Round constants, high byte of the Rcon word, indexed by round number
   localparam logic [7:0] AES_RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Byte k in FIPS-197 string order (byte 0 is the most significant)
   function automatic logic [7:0] get_byte(input logic [127:0] k, input int b);
      return k[127-8*b -: 8];
   endfunction

   // Word j in FIPS-197 string order (word 0 is the most significant)
   function automatic logic [31:0] get_word(input logic [127:0] k, input int w);
      return k[127-32*w -: 32];
   endfunction

   // RotWord: b0 b1 b2 b3 -> b1 b2 b3 b0
   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_inv_key_schedule_if.sv
// Key-schedule request/response bundle between key-load logic and the inverse-round controller.
// Latency: none (wiring only).
// Backpressure: key_ready from the consumer stalls round_key/round_idx.
interface aes_inv_key_schedule_if;
   import aes_pkg::*;

   logic                start;
   logic [KEY_BITS-1:0] key_last;
   logic [KEY_BITS-1:0] round_key;
   logic [3:0]          round_idx;
   logic                key_valid;
   logic                key_ready;
   logic                busy;
   logic                done;

   // master: the schedule generator; slave: requester and key consumer
   modport master (
      input  start, key_last, key_ready,
      output round_key, round_idx, key_valid, busy, done
   );

   modport slave (
      output start, key_last, key_ready,
      input  round_key, round_idx, key_valid, busy, done
   );

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, purely combinational.
// Latency: 0 cycles.
// Backpressure: none.
module aes_sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Table lookup
   assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Reverse AES-128 key expansion: from the round-10 key emits round keys 10 down to 0.
// Latency: first key one cycle after start, then one key per cycle while key_ready is high.
// Backpressure: with key_ready low the current key and index hold indefinitely.
module aes_inv_key_schedule #(
   parameter int WORD_SIZE  = 8,
   parameter int ARRAY_SIZE = 16,
   parameter int NR         = 10   // only 10 rounds is a legal configuration
) (
   input  logic                  clk,
   input  logic                  rst,
   aes_inv_key_schedule_if.master ks
);
   import aes_pkg::*;

   localparam int KW = WORD_SIZE * ARRAY_SIZE;

   sched_state_t  state;
   logic [KW-1:0] key_q;
   logic [3:0]    idx_q;
   logic          vld_q;
   logic          busy_q;
   logic          done_q;

   logic [31:0]   w0, w1, w2, w3;
   logic [31:0]   w0_n, w1_n, w2_n, w3_n;
   logic [31:0]   rot;
   logic [31:0]   sub;
   logic [7:0]    rcon_b;
   logic [KW-1:0] key_prev;
   logic          fire;

   assign w0 = get_word(key_q, 0);
   assign w1 = get_word(key_q, 1);
   assign w2 = get_word(key_q, 2);
   assign w3 = get_word(key_q, 3);

   // Undo the chained XORs first; w3' is the word the forward step fed to SubWord
   assign w3_n = w3 ^ w2;
   assign w2_n = w2 ^ w1;
   assign w1_n = w1 ^ w0;
   assign rot  = rot_word(w3_n);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_subword
         aes_sbox u_sbox (
            .in_byte  (rot[31-8*gi -: 8]),
            .out_byte (sub[31-8*gi -: 8])
         );
      end
   endgenerate

   // Rcon of the round that produced the current key; index 0 never advances
   assign rcon_b   = (idx_q >= 4'd1 && idx_q <= 4'd10) ? AES_RCON[idx_q] : 8'h00;
   assign w0_n     = w0 ^ sub ^ {rcon_b, 24'h000000};
   assign key_prev = {w0_n, w1_n, w2_n, w3_n};

   assign fire = vld_q & ks.key_ready;

   // Schedule FSM: load on start, step back one round per accepted key, pulse done after key 0
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         key_q  <= '0;
         idx_q  <= '0;
         vld_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (ks.start) begin
                  key_q  <= ks.key_last;
                  idx_q  <= 4'(NR);
                  vld_q  <= 1'b1;
                  busy_q <= 1'b1;
                  state  <= EMIT;
               end
            end
            EMIT: begin
               if (fire) begin
                  if (idx_q != 4'd0) begin
                     key_q <= key_prev;
                     idx_q <= idx_q - 4'd1;
                  end else begin
                     vld_q  <= 1'b0;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     state  <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ks.round_key = key_q;
   assign ks.round_idx = idx_q;
   assign ks.key_valid = vld_q;
   assign ks.busy      = busy_q;
   assign ks.done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for the reverse AES-128 key schedule: directed vectors with a scoreboard queue.
// Stimulus pushes the expected key sequence; a negedge monitor pops on every handshake.
// Done is checked every cycle against a flag armed by the index-0 handshake.
module tb_aes_inv_key_schedule;
   import aes_pkg::*;

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] key;
   } exp_t;

   localparam logic [127:0] OTHER_KEY = 128'h00112233445566778899aabbccddeeff;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   aes_inv_key_schedule_if ks_if ();

   aes_inv_key_schedule #(
      .WORD_SIZE  (8),
      .ARRAY_SIZE (16),
      .NR         (10)
   ) dut (
      .clk (clk),
      .rst (rst),
      .ks  (ks_if.master)
   );

   logic [127:0] fips_rk [0:10];
   logic [127:0] zero_rk [0:10];
   exp_t         exp_q [$];
   int           n_checks = 0;
   int           n_fail   = 0;
   logic         done_exp = 1'b0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_set(input logic is_zero);
      for (int r = 10; r >= 0; r--) begin
         exp_t e;
         e.idx = 4'(r);
         e.key = is_zero ? zero_rk[r] : fips_rk[r];
         exp_q.push_back(e);
      end
   endtask

   task automatic do_start(input logic [127:0] k);
      ks_if.start    = 1'b1;
      ks_if.key_last = k;
      tick();
      ks_if.start    = 1'b0;
   endtask

   task automatic wait_idx(input logic [3:0] t);
      bit found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         tick();
         if (ks_if.key_valid && ks_if.round_idx == t) found = 1'b1;
      end
      chk("wait_idx", 128'(found), 128'd1);
   endtask

   task automatic wait_done();
      bit found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         tick();
         if (ks_if.done) found = 1'b1;
      end
      chk("wait_done", 128'(found), 128'd1);
   endtask

   // Monitor: scoreboard pop on handshake, done pulse check every cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            done_exp = 1'b0;
         end else begin
            chk("done_pulse", 128'(ks_if.done), 128'(done_exp));
            done_exp = ks_if.key_valid && ks_if.key_ready && ks_if.round_idx == 4'd0;
            if (ks_if.key_valid && ks_if.key_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_key", 128'(exp_q.size()), 128'd1);
               end else begin
                  e = exp_q.pop_front();
                  chk("round_idx", 128'(ks_if.round_idx), 128'(e.idx));
                  chk("round_key", ks_if.round_key, e.key);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      int  nvalid;
      bit  got_done;

      fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
      fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      zero_rk[0]  = 128'h00000000000000000000000000000000;
      zero_rk[1]  = 128'h62636363626363636263636362636363;
      zero_rk[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
      zero_rk[3]  = 128'h90973450696ccffaf2f457330b0fac99;
      zero_rk[4]  = 128'hee06da7b876a1581759e42b27e91ee2b;
      zero_rk[5]  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
      zero_rk[6]  = 128'hec614b851425758c99ff09376ab49ba7;
      zero_rk[7]  = 128'h217517873550620bacaf6b3cc61bf09b;
      zero_rk[8]  = 128'h0ef903333ba9613897060a04511dfa9f;
      zero_rk[9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
      zero_rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

      ks_if.start     = 1'b0;
      ks_if.key_last  = '0;
      ks_if.key_ready = 1'b1;
      rst             = 1'b1;

      // Reset state
      repeat (3) tick();
      @(negedge clk);
      chk("rst_key",   ks_if.round_key, 128'd0);
      chk("rst_idx",   128'(ks_if.round_idx), 128'd0);
      chk("rst_valid", 128'(ks_if.key_valid), 128'd0);
      chk("rst_busy",  128'(ks_if.busy), 128'd0);
      chk("rst_done",  128'(ks_if.done), 128'd0);
      tick();
      rst = 1'b0;
      tick();

      // FIPS-197 vector, consumer always ready
      push_set(1'b0);
      do_start(fips_rk[10]);
      chk("start_latency_valid", 128'(ks_if.key_valid), 128'd1);
      chk("start_busy", 128'(ks_if.busy), 128'd1);
      nvalid   = 0;
      got_done = 1'b0;
      for (int i = 0; i < 40 && !got_done; i++) begin
         @(negedge clk);
         if (ks_if.key_valid) nvalid++;
         if (ks_if.done) got_done = 1'b1;
      end
      chk("valid_run_len", 128'(nvalid), 128'd11);
      chk("done_seen", 128'(got_done), 128'd1);
      tick();
      chk("idle_busy", 128'(ks_if.busy), 128'd0);
      chk("idle_valid", 128'(ks_if.key_valid), 128'd0);
      chk("idle_key_hold", ks_if.round_key, fips_rk[0]);
      chk("idle_idx_hold", 128'(ks_if.round_idx), 128'd0);

      // Zero-key schedule
      push_set(1'b1);
      do_start(zero_rk[10]);
      wait_done();
      tick();

      // Backpressure at index 7 for five cycles
      push_set(1'b0);
      do_start(fips_rk[10]);
      wait_idx(4'd7);
      ks_if.key_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_idx", 128'(ks_if.round_idx), 128'd7);
         chk("bp_key", ks_if.round_key, fips_rk[7]);
         chk("bp_valid", 128'(ks_if.key_valid), 128'd1);
      end
      @(posedge clk);
      #1;
      ks_if.key_ready = 1'b1;
      wait_done();
      tick();

      // start while busy is ignored
      push_set(1'b0);
      do_start(fips_rk[10]);
      wait_idx(4'd5);
      ks_if.start    = 1'b1;
      ks_if.key_last = OTHER_KEY;
      tick();
      ks_if.start    = 1'b0;
      wait_done();
      tick();

      // Reset in the middle of a schedule
      push_set(1'b0);
      do_start(fips_rk[10]);
      wait_idx(4'd4);
      rst = 1'b1;
      exp_q.delete();
      tick();
      @(negedge clk);
      chk("midrst_key",   ks_if.round_key, 128'd0);
      chk("midrst_idx",   128'(ks_if.round_idx), 128'd0);
      chk("midrst_valid", 128'(ks_if.key_valid), 128'd0);
      chk("midrst_busy",  128'(ks_if.busy), 128'd0);
      chk("midrst_done",  128'(ks_if.done), 128'd0);
      rst = 1'b0;
      repeat (2) tick();
      push_set(1'b0);
      do_start(fips_rk[10]);
      wait_done();

      // Back-to-back: start during the done cycle
      push_set(1'b1);
      do_start(zero_rk[10]);
      chk("b2b_valid", 128'(ks_if.key_valid), 128'd1);
      chk("b2b_idx", 128'(ks_if.round_idx), 128'd10);
      chk("b2b_busy", 128'(ks_if.busy), 128'd1);
      wait_done();
      repeat (3) tick();

      chk("queue_drained", 128'(exp_q.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
- Iterative reverse AES-128 key expansion for the decryption datapath.
- Takes the final (round-10) round key and emits round keys 10, 9, …, 0 in descending order, one per handshake.
- Output feeds the key input of the decryption-side AddRoundKey stage, so no 11-entry key RAM is needed.
- Sits between the key-load logic and the inverse-round controller.

Parameters:
- WORD_SIZE, 8, bits per state byte.
- ARRAY_SIZE, 16, bytes per key/state; the key is WORD_SIZE*ARRAY_SIZE = 128 bits.
- NR, 10, number of rounds. Only 10 is supported; any other value is illegal.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  1-cycle request to begin a schedule. Sampled only in IDLE.
- key_last  input  128  round-10 key. Captured on an accepted start.
- round_key  output  128  current round key.
- round_idx  output  4  round number of round_key, 10 down to 0.
- key_valid  output  1  round_key and round_idx are valid.
- key_ready  input  1  consumer accepts the current key.
- busy  output  1  high from the accepted start until done.
- done  output  1  1-cycle pulse after key 0 is accepted.

Behaviour:
- Byte/word order (FIPS-197 string order):
  - byte k = bits [127-8k -: 8].
  - word w_j = bits [127-32j -: 32], j = 0..3.
- Reset (rst=1 at a clock edge):
  - round_key = 0, round_idx = 0, key_valid = 0, busy = 0, done = 0; state = IDLE.
  - Overrides every other input, including mid-schedule.
  - Any schedule in progress is abandoned with no done pulse.
- States: IDLE, EMIT.
- IDLE:
  - done = 0.
  - start = 1: round_key <= key_last, round_idx <= 10, key_valid <= 1, busy <= 1, go to EMIT.
  - Latency: the key is presented the cycle after start.
- EMIT:
  - Handshake fires when key_valid & key_ready.
  - No handshake: round_key and round_idx hold exactly (backpressure, unbounded).
  - Handshake with round_idx > 0: next-cycle round_key = prev(round_key, round_idx), round_idx decrements, key_valid stays 1. Throughput is one key per cycle when key_ready is held high.
  - Handshake with round_idx = 0: key_valid <= 0, busy <= 0, done <= 1 for exactly one cycle, go to IDLE. round_key and round_idx keep their last values.
- start is ignored while in EMIT, and also in the done cycle's preceding edge.
- start asserted in the same cycle done is high is accepted, because the block is already in IDLE.
- prev(K, i), with w0..w3 the words of K:
  - w3' = w3 ^ w2
  - w2' = w2 ^ w1
  - w1' = w1 ^ w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[i], 24'h0}
  - RotWord(b0 b1 b2 b3) = b1 b2 b3 b0.
  - SubWord applies the forward AES S-box to each byte.
  - Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- Computation is combinational from the registered round_key and registered into round_key on the handshake. No multi-cycle steps.
- round_idx never underflows. The handshake at index 0 terminates the schedule.

Decomposition:
- Shared package aes_pkg:
  - AES_RCON[1:10] constant.
  - KEY_BITS = 128, NR = 10.
  - State enum {IDLE, EMIT}.
  - Byte/word slice helper functions.
- Sub-module aes_sbox: 8-bit combinational forward S-box. Instantiated 4× for SubWord and shared with the encryption SubBytes stage.
- The schedule FSM, word XOR and Rcon select stay in this module.

Test Plan:
- FIPS-197 vector, key_ready=1:
  - start with key_last = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Next cycle: idx 10 with that key. Following cycle: idx 9 = ac7766f319fadc2128d12941575c006e.
  - idx 1 = a0fafe1788542cb123a339392a6c7605; idx 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - done pulses one cycle after idx 0 is accepted.
  - 11 consecutive valid cycles in total.
- Zero key:
  - start with key_last = b4ef5bcb3e92e21123e951cf6f8f188e.
  - idx 0 = all zeros; done = 1 for exactly one cycle.
- Backpressure:
  - Drop key_ready for 5 cycles at idx 7.
  - round_key and round_idx stay stable, key_valid stays 1.
  - Resume: idx 6 is correct and no key is skipped or duplicated.
- start while busy:
  - Pulse start with a different key_last at idx 5.
  - Sequence continues unaffected, with identical keys to the first test.
- Reset at idx 4:
  - Next cycle all outputs are 0, no done pulse.
  - A subsequent start yields the full correct sequence.
- Back-to-back: start asserted in the done cycle is accepted, and idx 10 appears the next cycle.
